// File: rtl/i2s_tx.sv
// i2s_tx: mono-to-stereo I2S serializer.
//
// Takes one signed mixed sample per audio frame through a valid/ready
// handshake and transmits it on both the left and the right slot of a
// standard I2S frame. All I2S timing (BCLK, LRCLK, SDATA) is derived from the
// system clock by a divider. If no sample is waiting when a frame begins, the
// frame carries silence and underrun pulses for one cycle.
//
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous, active-high reset
//   sample_in         signed mixed sample (two's complement, WIDTH bits)
//   sample_valid_in   sample_in is valid this cycle
//   sample_ready_out  block can accept a sample (combinational, !hold_valid)
//   bclk_out          I2S bit clock (registered)
//   lrclk_out         I2S word select, 0 = left slot, 1 = right slot (registered)
//   sdata_out         I2S serial data, MSB first (registered)
//   underrun_out      one-cycle pulse when a frame starts with no sample held
module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_out,
  output logic                    underrun_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] WIDTH_K  = BIT_W'(WIDTH);

  // Serial bit for slot position k: position 0 is the I2S one-BCLK delay
  // slot, positions 1..WIDTH carry the sample MSB first, the rest pad with 0.
  function automatic logic slot_bit(input logic signed [WIDTH-1:0] s,
                                    input logic [BIT_W-1:0]        k);
    logic [WIDTH-1:0] shifted;
    shifted = '0;
    if (k == '0 || k > WIDTH_K) begin
      return 1'b0;
    end
    shifted = s << (k - BIT_W'(1));
    return shifted[WIDTH-1];
  endfunction

  // State registers
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic signed [WIDTH-1:0] hold;
  logic                    hold_valid;
  logic signed [WIDTH-1:0] frame_sample;

  // Next-state values
  logic [DIV_W-1:0]        div_nxt;
  logic                    bclk_nxt;
  logic [BIT_W-1:0]        bit_nxt;
  logic                    lrclk_nxt;
  logic                    sdata_nxt;
  logic                    underrun_nxt;
  logic                    hold_valid_nxt;
  logic signed [WIDTH-1:0] frame_nxt;

  // Event decode
  logic                    div_wrap;
  logic                    fall;
  logic [BIT_W-1:0]        bit_adv;
  logic [BIT_W-1:0]        k_adv;
  logic                    frame_start;
  logic                    accept;

  assign sample_ready_out = !hold_valid;
  assign accept           = sample_valid_in && !hold_valid;

  assign div_wrap    = (div_cnt == DIV_LAST);
  // BCLK falls when the divider wraps while BCLK is high.
  assign fall        = div_wrap && bclk_out;
  assign bit_adv     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign k_adv       = (bit_adv >= SLOT_LEN) ? bit_adv - SLOT_LEN : bit_adv;
  assign frame_start = fall && (bit_adv == '0);

  always_comb begin
    div_nxt        = div_wrap ? '0 : div_cnt + DIV_W'(1);
    bclk_nxt       = div_wrap ? ~bclk_out : bclk_out;
    bit_nxt        = bit_cnt;
    lrclk_nxt      = lrclk_out;
    sdata_nxt      = sdata_out;
    underrun_nxt   = 1'b0;
    hold_valid_nxt = hold_valid;
    frame_nxt      = frame_sample;

    if (fall) begin
      bit_nxt   = bit_adv;
      lrclk_nxt = (bit_adv >= SLOT_LEN);
      // At k=0 the old frame_sample is never read, so the frame-start reload
      // below does not race with the serializer.
      sdata_nxt = slot_bit(frame_sample, k_adv);
    end

    // Frame start looks at hold_valid from before the edge; an accept on the
    // same edge into an empty hold still counts as an underrun.
    if (frame_start) begin
      if (hold_valid) begin
        frame_nxt      = hold;
        hold_valid_nxt = 1'b0;
      end else begin
        frame_nxt    = '0;
        underrun_nxt = 1'b1;
      end
    end

    // accept implies hold_valid was low, so it never collides with a release.
    if (accept) begin
      hold_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      bclk_out     <= 1'b0;
      bit_cnt      <= BIT_LAST;
      lrclk_out    <= 1'b0;
      sdata_out    <= 1'b0;
      underrun_out <= 1'b0;
      hold_valid   <= 1'b0;
      frame_sample <= '0;
    end else begin
      div_cnt      <= div_nxt;
      bclk_out     <= bclk_nxt;
      bit_cnt      <= bit_nxt;
      lrclk_out    <= lrclk_nxt;
      sdata_out    <= sdata_nxt;
      underrun_out <= underrun_nxt;
      hold_valid   <= hold_valid_nxt;
      frame_sample <= frame_nxt;
    end
  end

  // Sample holding register; its contents only matter while hold_valid is set.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      hold <= sample_in;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

  localparam int WIDTH = 16;
  localparam int SB    = 32;
  localparam int CD    = 2;
  localparam int FRAME = 2 * SB * 2 * CD;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] sample_in = '0;
  logic                    sample_valid_in = 1'b0;
  logic                    sample_ready_out;
  logic                    bclk_out;
  logic                    lrclk_out;
  logic                    sdata_out;
  logic                    underrun_out;

  i2s_tx #(.WIDTH(WIDTH), .SLOT_BITS(SB), .CLK_DIV(CD)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .bclk_out         (bclk_out),
    .lrclk_out        (lrclk_out),
    .sdata_out        (sdata_out),
    .underrun_out     (underrun_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int               t;
  int               abs_cyc = 0;
  logic [WIDTH-1:0] m_hold;
  logic             m_hold_v;
  logic [WIDTH-1:0] m_cur;
  logic             m_under;
  bit               have_frame;
  bit               fs_last;
  bit               acc_last;
  logic [SB-1:0]    cap_l, cap_r, last_l, last_r;
  int               under_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit carried at slot position k: k=1 is the MSB, k=WIDTH the LSB.
  function automatic logic exp_bit(input logic [WIDTH-1:0] s, input int k);
    if (k < 1 || k > WIDTH) return 1'b0;
    return ((s >> (WIDTH - k)) & 1) != 0;
  endfunction

  function automatic logic [SB-1:0] slot_vec(input logic [WIDTH-1:0] s);
    logic [SB-1:0] v;
    v = '0;
    for (int k = 0; k < SB; k++) v[k] = exp_bit(s, k);
    return v;
  endfunction

  // Falling BCLK edges happen every 2*CD cycles; the first is a frame start,
  // then every 2*SB falls after that.
  function automatic bit is_fs(input int tt);
    if (tt <= 0 || (tt % (2 * CD)) != 0) return 1'b0;
    return (((tt / (2 * CD)) - 1) % (2 * SB)) == 0;
  endfunction

  task automatic reset_model();
    t = 0;
    m_hold_v = 1'b0;
    m_hold = '0;
    m_cur = '0;
    m_under = 1'b0;
    have_frame = 1'b0;
    cap_l = '0;
    cap_r = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_bclk"}, bclk_out, 0);
    chk({tag, "_lrclk"}, lrclk_out, 0);
    chk({tag, "_sdata"}, sdata_out, 0);
    chk({tag, "_underrun"}, underrun_out, 0);
    chk({tag, "_ready"}, sample_ready_out, 1);
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    logic             pre;
    logic [WIDTH-1:0] old_cur;
    int               n, b, k;
    sample_valid_in = v;
    sample_in = d;
    @(posedge clk);
    t++;
    abs_cyc++;
    pre = m_hold_v;
    old_cur = m_cur;
    fs_last = is_fs(t);
    acc_last = v && !pre;
    m_under = fs_last && !pre;
    if (fs_last) begin
      m_cur = pre ? m_hold : '0;
      m_hold_v = 1'b0;
    end
    if (acc_last) begin
      m_hold_v = 1'b1;
      m_hold = d;
    end
    #1;
    n = t / (2 * CD);
    b = (n > 0) ? (n - 1) % (2 * SB) : 0;
    k = b % SB;
    chk("bclk", bclk_out, (t / CD) % 2);
    chk("lrclk", lrclk_out, (n > 0 && b >= SB) ? 1 : 0);
    chk("sdata", sdata_out, (n > 0) ? exp_bit(m_cur, k) : 1'b0);
    chk("underrun", underrun_out, m_under);
    chk("ready", sample_ready_out, !m_hold_v);
    if (fs_last) begin
      if (have_frame) begin
        chk("frame_left", cap_l, slot_vec(old_cur));
        chk("frame_right", cap_r, slot_vec(old_cur));
      end
      last_l = cap_l;
      last_r = cap_r;
      have_frame = 1'b1;
    end
    if (underrun_out) under_times.push_back(abs_cyc);
    if (n > 0 && (t % (2 * CD)) == 0) begin
      if (b < SB) cap_l[k] = sdata_out;
      else cap_r[k] = sdata_out;
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    int guard;
    guard = 0;
    acc_last = 1'b0;
    while (!acc_last && guard < 2 * FRAME) begin
      step(1'b1, d);
      guard++;
    end
    sample_valid_in = 1'b0;
    if (!acc_last) begin
      failures++;
      $error("FAIL push_timeout observed=%0d expected<%0d", guard, 2 * FRAME);
    end
  endtask

  task automatic idle_to_fs();
    int guard;
    guard = 0;
    fs_last = 1'b0;
    while (!fs_last && guard <= FRAME) begin
      step(1'b0, WIDTH'($urandom));
      guard++;
    end
    if (!fs_last) begin
      failures++;
      $error("FAIL frame_timeout observed=%0d expected<=%0d", guard, FRAME);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_idle("reset");

    // First frame starts at cycle 4 with nothing held.
    idle_to_fs();
    chk("first_fs_under", underrun_out, 1);

    push(16'h8001);
    idle_to_fs();
    push(16'hFFFF);
    idle_to_fs();
    chk("p8001_left", last_l, 32'h0001_0002);
    chk("p8001_right", last_r, 32'h0001_0002);

    // Backpressure: 0x5678 waits until 0x1234 is released.
    push(16'h1234);
    push(16'h5678);
    chk("pFFFF_left", last_l, 32'h0001_FFFE);
    chk("pFFFF_right", last_r, 32'h0001_FFFE);
    idle_to_fs();
    chk("p1234_left", last_l, slot_vec(16'h1234));
    idle_to_fs();
    chk("p5678_right", last_r, slot_vec(16'h5678));

    // Starvation over three frames.
    under_times.delete();
    repeat (3) idle_to_fs();
    chk("starve_count", under_times.size(), 3);
    if (under_times.size() == 3) begin
      chk("starve_gap1", under_times[1] - under_times[0], FRAME);
      chk("starve_gap2", under_times[2] - under_times[1], FRAME);
    end
    chk("starve_sdata", last_l | last_r, 0);

    // Asynchronous reset in the right slot with a sample held.
    push(16'h7EED);
    repeat (42 * 2 * CD) step(1'b0, '0);
    chk("pre_rst_lrclk", lrclk_out, 1);
    chk("pre_rst_ready", sample_ready_out, 0);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_idle("rst_release");
    idle_to_fs();
    chk("post_rst_under", underrun_out, 1);
    idle_to_fs();
    chk("post_rst_silent", last_l | last_r, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1800; i++) begin
      step(($urandom % 8) == 0, WIDTH'($urandom));
    end
    idle_to_fs();
    idle_to_fs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
